// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and datapath-select encodings shared by the multicycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
        EXEC_R, EXEC_I, ALU_WB, BEQ, JAL, HALT
    } state_t;

    localparam int WAIT_W = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/ctrl_mem_wait.sv
// ctrl_mem_wait: counts unacknowledged memory request cycles and flags the timeout limit.
module ctrl_mem_wait
    import ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;

    assign timeout = cnt == WAIT_W'(LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for a unified-memory core.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_WIDTH    = 7,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                eq,
    input  logic                mem_ack,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_req,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          imm_src,
    output logic                illegal,
    output logic                bus_err
);

    state_t state, next;
    logic   started, wait_st, timeout, ack;

    // started keeps the very first post-reset cycle free of any memory request
    assign wait_st   = started && (state == FETCH || state == MEM_RD || state == MEM_WR);
    assign mem_req   = wait_st && !timeout;
    assign ack       = mem_req && mem_ack;
    assign mem_write = mem_req && state == MEM_WR;

    ctrl_mem_wait #(.LIMIT(MEM_TIMEOUT)) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!mem_req || mem_ack),
        .en      (mem_req),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= FETCH;
            started <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state   <= next;
            started <= 1'b1;
            bus_err <= bus_err || (wait_st && timeout);
        end

    always_comb begin
        next       = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        imm_src    = IMM_I;
        case (state)
            FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (ack) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    result_src = RES_ALURESULT;
                    next       = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                if (op == OP_LOAD || op == OP_STORE) next = MEM_ADR;
                else if (op == OP_RTYPE) next = EXEC_R;
                else if (op == OP_ITYPE) next = EXEC_I;
                else if (op == OP_BRANCH) next = BEQ;
                else if (op == OP_JAL) next = JAL;
                else begin
                    illegal = 1'b1;
                    next    = FETCH;
                end
            end
            MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = op == OP_STORE ? IMM_S : IMM_I;
                next      = op == OP_STORE ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                adr_src = 1'b1;
                if (ack) next = MEM_WB;
            end
            MEM_WB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                next       = FETCH;
            end
            MEM_WR: begin
                adr_src = 1'b1;
                if (ack) next = FETCH;
            end
            EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                next      = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                imm_src   = IMM_I;
                next      = ALU_WB;
            end
            ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                next       = FETCH;
            end
            BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                pc_write  = eq;
                next      = FETCH;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                imm_src   = IMM_J;
                pc_write  = 1'b1;
                next      = ALU_WB;
            end
            HALT: next = HALT;
            default: next = FETCH;
        endcase
        if (wait_st && timeout) next = HALT;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle scoreboard check of the multicycle controller outputs.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, eq, mem_ack;
    logic [6:0] op;
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal, bus_err;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [17:0] got;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .eq         (eq),
        .mem_ack    (mem_ack),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, bus_err}
    assign got = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal, bus_err};

    localparam logic [17:0] F0      = 18'b0_0_0_0_0_0_00_00_10_00_00_0_0;
    localparam logic [17:0] FW      = 18'b0_0_1_0_0_0_00_00_10_00_00_0_0;
    localparam logic [17:0] FA      = 18'b1_0_1_0_1_0_10_00_10_00_00_0_0;
    localparam logic [17:0] DEC     = 18'b0_0_0_0_0_0_00_01_01_00_10_0_0;
    localparam logic [17:0] DEC_ILL = 18'b0_0_0_0_0_0_00_01_01_00_10_1_0;
    localparam logic [17:0] EXR     = 18'b0_0_0_0_0_0_00_10_00_10_00_0_0;
    localparam logic [17:0] EXI     = 18'b0_0_0_0_0_0_00_10_01_10_00_0_0;
    localparam logic [17:0] AWB     = 18'b0_0_0_0_0_1_00_00_00_00_00_0_0;
    localparam logic [17:0] MADR_LW = 18'b0_0_0_0_0_0_00_10_01_00_00_0_0;
    localparam logic [17:0] MADR_SW = 18'b0_0_0_0_0_0_00_10_01_00_01_0_0;
    localparam logic [17:0] MRD     = 18'b0_1_1_0_0_0_00_00_00_00_00_0_0;
    localparam logic [17:0] MWB     = 18'b0_0_0_0_0_1_01_00_00_00_00_0_0;
    localparam logic [17:0] MWR     = 18'b0_1_1_1_0_0_00_00_00_00_00_0_0;
    localparam logic [17:0] MWR_TO  = 18'b0_1_0_0_0_0_00_00_00_00_00_0_0;
    localparam logic [17:0] BEQ_T   = 18'b1_0_0_0_0_0_00_10_00_01_00_0_0;
    localparam logic [17:0] BEQ_N   = 18'b0_0_0_0_0_0_00_10_00_01_00_0_0;
    localparam logic [17:0] JALV    = 18'b1_0_0_0_0_0_00_01_10_00_11_0_0;
    localparam logic [17:0] HALTV   = 18'b0_0_0_0_0_0_00_00_00_00_00_0_1;

    string       nmq[$];
    logic [17:0] vq[$];
    int          checks = 0, errors = 0;

    always @(negedge clk)
        if (vq.size() > 0) begin
            string       n;
            logic [17:0] e;
            n = nmq.pop_front();
            e = vq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", n, got, e);
            end
        end

    task automatic cyc(input string n, input logic ack, input logic [17:0] e);
        mem_ack = ack;
        nmq.push_back(n);
        vq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; op = '0; eq = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_hold", 1, F0);
        rst_n = 1'b1;
        cyc("first_after_rst", 1, F0);
        op = 7'b0110011;
        cyc("r_fetch", 1, FA); cyc("r_decode", 1, DEC); cyc("r_exec", 1, EXR); cyc("r_wb", 1, AWB);
        op = 7'b0000011;
        repeat (3) cyc("lw_fetch_wait", 0, FW);
        cyc("lw_fetch", 1, FA); cyc("lw_decode", 1, DEC); cyc("lw_adr", 1, MADR_LW);
        repeat (3) cyc("lw_rd_wait", 0, MRD);
        cyc("lw_rd", 1, MRD); cyc("lw_wb", 1, MWB);
        op = 7'b1100011; eq = 1'b1;
        cyc("beq_t_fetch", 1, FA); cyc("beq_t_decode", 1, DEC); cyc("beq_taken", 1, BEQ_T);
        eq = 1'b0;
        cyc("beq_n_fetch", 1, FA); cyc("beq_n_decode", 1, DEC); cyc("beq_not_taken", 1, BEQ_N);
        op = 7'b1111111;
        cyc("ill_fetch", 1, FA); cyc("ill_decode", 1, DEC_ILL);
        op = 7'b0010011;
        cyc("i_fetch", 1, FA); cyc("i_decode", 1, DEC); cyc("i_exec", 1, EXI); cyc("i_wb", 1, AWB);
        op = 7'b1101111;
        cyc("jal_fetch", 1, FA); cyc("jal_decode", 1, DEC); cyc("jal", 1, JALV); cyc("jal_wb", 1, AWB);
        op = 7'b0100011;
        cyc("sw_fetch", 1, FA); cyc("sw_decode", 1, DEC); cyc("sw_adr", 1, MADR_SW); cyc("sw_wr", 1, MWR);
        cyc("to_fetch", 1, FA); cyc("to_decode", 1, DEC); cyc("to_adr", 1, MADR_SW);
        repeat (255) cyc("to_wr_wait", 0, MWR);
        cyc("to_timeout", 1, MWR_TO);
        repeat (3) cyc("to_halt", 1, HALTV);
        rst_n = 1'b0;
        cyc("halt_rst", 1, F0);
        rst_n = 1'b1;
        cyc("halt_rst_release", 1, F0);
        cyc("rw_fetch", 1, FA); cyc("rw_decode", 1, DEC); cyc("rw_adr", 1, MADR_SW);
        repeat (2) cyc("rw_wr_wait", 0, MWR);
        rst_n = 1'b0;
        cyc("rst_mid_wr", 1, F0);
        cyc("rst_mid_held", 1, F0);
        rst_n = 1'b1;
        cyc("rst_mid_release", 1, F0);
        cyc("refetch", 1, FA);
        @(negedge clk);
        #1;
        checks++;
        if (vq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", vq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
